// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts an unsigned value on start and presents packed BCD digits on bcd,
// with units in bits [3:0]. A one-cycle done pulse marks each new result.
// Digits above DIGITS are dropped, so the result is the value mod 10^DIGITS.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | one double-dabble iteration per clock, WIDTH iterations in total
// S_DONE  | result just written to bcd, done high for this single cycle
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] bin_reg;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   adjusted;
  logic [BW-1:0]   scratch_shift;
  logic [CW-1:0]   bit_cnt;
  logic            accept;
  logic            last_bit;

  // A request is taken whenever no conversion is in flight, including the DONE cycle.
  assign accept   = start && (state != S_SHIFT);
  assign last_bit = (bit_cnt == CW'(1));

  // Pre-adjust every nibble >= 5 by +3, then form the shifted scratch value.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    scratch_shift = {adjusted[BW-2:0], bin_reg[WIDTH-1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = start ? S_SHIFT : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift while converting, publish on the last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
    end else if (accept) begin
      bin_reg <= bin;
      scratch <= '0;
      bit_cnt <= CW'(WIDTH);
    end else if (state == S_SHIFT) begin
      bin_reg <= bin_reg << 1;
      scratch <= scratch_shift;
      bit_cnt <= bit_cnt - CW'(1);
      if (last_bit) begin
        bcd <= scratch_shift;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver pushes the decimal reference
// result and its expected completion cycle; a negedge monitor checks done,
// busy and bcd every cycle against the queue.
module tb_bin2bcd_seq;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic        busy, done;
  logic [11:0] bcd;

  logic        start2 = 1'b0;
  logic [7:0]  bin2 = 8'd0;
  logic        busy2, done2;
  logic [7:0]  bcd2;

  logic        start3 = 1'b0;
  logic [9:0]  bin3 = 10'd0;
  logic        busy3, done3;
  logic [15:0] bcd3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int held = 0;

  typedef struct {
    int val;
    int done_cyc;
  } exp_t;
  exp_t q[$];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bin(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp accepts and completions.
  always @(posedge clk) cyc++;

  // Decimal reference: digits by repeated division, top digits dropped.
  function automatic int to_bcd(int v, int digits);
    int res = 0;
    int t = v;
    for (int d = 0; d < digits; d++) begin
      res = res | ((t % 10) << (4 * d));
      t = t / 10;
    end
    return res;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares status and result every cycle against the scoreboard.
  bit exp_done, exp_busy;
  always @(negedge clk) begin
    if (!rst) begin
      exp_done = (q.size() > 0) && (q[0].done_cyc == cyc);
      exp_busy = 1'b0;
      foreach (q[i]) begin
        if (cyc >= q[i].done_cyc - W && cyc < q[i].done_cyc) exp_busy = 1'b1;
      end
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_done) begin
        chk("bcd_result", 32'(bcd), 32'(q[0].val));
        held = q[0].val;
        void'(q.pop_front());
      end else begin
        chk("bcd_hold", 32'(bcd), 32'(held));
      end
    end
  end

  // Caller is at posedge+1; the next edge accepts the request.
  task automatic issue(int v);
    exp_t e;
    start = 1'b1;
    bin = 8'(v);
    e.val = to_bcd(v, 3);
    e.done_cyc = cyc + 1 + W;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    bin = 8'($urandom);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) tick(1);
    if (q.size() > 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic wait_until(int t);
    for (int k = 0; k < 40 && cyc < t; k++) tick(1);
  endtask

  task automatic run_aux2(int v, int exp);
    int lat = 0;
    start2 = 1'b1;
    bin2 = 8'(v);
    tick(1);
    start2 = 1'b0;
    while (!done2 && lat < 40) begin
      tick(1);
      lat++;
    end
    chk("p2_latency", 32'(lat), 32'd8);
    chk("p2_bcd", 32'(bcd2), 32'(exp));
  endtask

  task automatic run_aux3(int v, int exp);
    int lat = 0;
    start3 = 1'b1;
    bin3 = 10'(v);
    tick(1);
    start3 = 1'b0;
    while (!done3 && lat < 40) begin
      tick(1);
      lat++;
    end
    chk("p3_latency", 32'(lat), 32'd10);
    chk("p3_bcd", 32'(bcd3), 32'(exp));
  endtask

  logic [7:0] cnt8;
  int first_done;
  int v;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);

    // Directed values, including the full-scale case.
    issue(255); drain();
    issue(0);   drain();
    issue(99);  drain();
    issue(100); drain();
    issue(9);   drain();

    // Start during SHIFT is ignored; start during DONE chains the next one.
    issue(200);
    first_done = q[0].done_cyc;
    tick(2);
    start = 1'b1;
    bin = 8'd17;
    tick(1);
    start = 1'b0;
    bin = 8'd88;
    wait_until(first_done);
    chk("chain_align", 32'(cyc), 32'(first_done));
    issue(17);
    chk("chain_gap", 32'(q[$].done_cyc - first_done), 32'd9);
    drain();

    // Reset mid-conversion discards the result; no done may follow.
    issue(123);
    tick(3);
    rst = 1'b1;
    q.delete();
    held = 0;
    tick(1);
    rst = 1'b0;
    tick(15);
    issue(45); drain();

    // Counter-driven sweep, up then down with wrap.
    cnt8 = 8'd0;
    repeat (256) begin
      issue(int'(cnt8)); drain();
      cnt8 = cnt8 + 8'd1;
    end
    cnt8 = 8'd0;
    repeat (256) begin
      issue(int'(cnt8)); drain();
      cnt8 = cnt8 - 8'd1;
    end

    // Random values, randomly chained back-to-back or spaced apart.
    for (int i = 0; i < 60; i++) begin
      v = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) begin
        if (q.size() > 0) wait_until(q[$].done_cyc);
      end else begin
        drain();
        tick($urandom_range(0, 3));
      end
      issue(v);
    end
    drain();

    // Other parameterisations.
    run_aux2(255, 'h55);
    run_aux2(7, 'h07);
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 255);
      run_aux2(v, to_bcd(v, 2));
      tick(1);
    end
    run_aux3(1023, 'h1023);
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 1023);
      run_aux3(v, to_bcd(v, 4));
      tick(1);
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly downstream of the 8-bit up/down counter.
- Takes the counter's unsigned `count` value and produces packed BCD digits for the 7-segment / display stage.
- Uses a start/done handshake and one shift per clock, so the logic stays small and the critical path stays short.

Parameters:
- WIDTH, 8, width of the unsigned binary input; matches the counter width.
- DIGITS, 3, number of 4-bit BCD output digits; the default covers 0..255.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a conversion of `bin`. Accepted only when `busy`=0.
- bin  input  WIDTH  unsigned binary value. Sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new result is on `bcd`.
- bcd  output  4*DIGITS  packed BCD result. Digit 0 (units) is in bits [3:0]. Held until the next completion.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - All state updates on posedge clk.
- Reset:
  - rst=1 at an edge forces state=IDLE, busy=0, done=0, bcd=0, and clears the internal shift registers and bit counter.
  - Reset overrides start and any in-flight conversion; the partial result is discarded and `bcd` reads 0.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1; lasts exactly one cycle.
- Transitions:
  - IDLE or DONE, start=1: capture `bin` into the binary shift register, clear the BCD scratch register, load the bit counter with WIDTH, go to SHIFT.
  - DONE, start=0: go to IDLE.
  - SHIFT: perform one iteration per edge. After the WIDTH-th iteration, write the scratch value to `bcd` and go to DONE.
- One SHIFT iteration, in this order within a single cycle (combinational pre-adjust, then registered shift):
  - Add 3 to every scratch nibble whose value is ≥5.
  - Shift {scratch, binreg} left by 1; the binreg MSB enters scratch bit 0.
  - Decrement the bit counter.
- Latency:
  - start sampled at edge k → `bcd` updated and done=1 after edge k+WIDTH.
  - `done` is high for the single cycle between edges k+WIDTH and k+WIDTH+1.
  - Default: 8 cycles from accept to result.
- Throughput:
  - start may be asserted during DONE, giving back-to-back conversions every WIDTH+1 cycles.
  - In that case `done` drops and busy=1 on the following cycle.
- start while busy=1 is ignored; no queuing. `bin` changes during SHIFT have no effect.
- Width rule:
  - If 10^DIGITS ≤ 2^WIDTH−1, the result is the value mod 10^DIGITS (high digits are truncated by the shift-out).
  - No error flag is produced.
- Every `bcd` nibble is always in 0..9 after reset or any completion.
- `bcd` never changes except at completion or reset. There are no intermediate values on the output.

Test Plan:
- Reset, then start=1 for one cycle with bin=8'd255 → busy=1 for 8 cycles, then done=1 for exactly 1 cycle, and bcd=12'h255. Check that done rises exactly 8 edges after the accepting edge.
- bin=0 → bcd=12'h000 after 8 cycles. Then bin=99 → 12'h099. Then bin=100 → 12'h100. Then bin=9 → 12'h009.
- Start bin=200; at cycle 3 of SHIFT assert start with bin=17 and change `bin` → request ignored, result is 12'h200. Then re-assert start during the DONE cycle with bin=17 → 12'h017 exactly 9 cycles after the first done.
- Start bin=123, assert rst at cycle 4 of SHIFT → next cycle busy=0, done=0, bcd=0. No done pulse follows. A fresh start with bin=45 → 12'h045.
- Exhaustive check: drive bin from the counter (en=1) for all 0..255, one conversion per value → every result matches a decimal reference model. Repeat with en=0 (down-count wrap 0→255): result 12'h255 follows 12'h000.
- Parameter check: WIDTH=8, DIGITS=2, bin=255 → bcd=8'h55 (mod 100). WIDTH=10, DIGITS=4, bin=1023 → 16'h1023 after 10 cycles.
